// File: rtl/seq_mul_hs.sv
// Iterative shift-add N x N -> 2N multiplier (unsigned or signed per transaction) with valid/ready handshakes.
// Optional macro SEQ_MUL_ZERO_SKIP_EN: zero operands bypass the iteration and complete in one cycle.
module seq_mul_hs #(
   parameter int N = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   input  logic           sgn,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] p,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [N-1:0]     mcand_q;
   logic [N-1:0]     mplier_q;
   logic [2*N-1:0]   acc_q;
   logic [2*N-1:0]   acc_nxt;
   logic [N:0]       sum_hi;
   logic             neg_q;
   logic [2*N-1:0]   p_q;
   logic             xfer;
   logic             zero_op;

   // Magnitude of an operand; the most negative value maps to 2^(N-1), which still fits unsigned.
   function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic s);
      logic signed [N-1:0] sv;
      sv = v;
      return (s && v[N-1]) ? N'(-sv) : v;
   endfunction

   function automatic logic [2*N-1:0] neg2(input logic [2*N-1:0] v);
      logic signed [2*N-1:0] sv;
      sv = v;
      return (2*N)'(-sv);
   endfunction

`ifdef SEQ_MUL_ZERO_SKIP_EN
   assign zero_op = (x == '0) || (y == '0);
`else
   assign zero_op = 1'b0;
`endif

   assign in_ready  = rst_n && (state_q == IDLE);
   assign xfer      = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign p         = p_q;

   // One partial-product row: add into the upper half, then shift {carry, acc} right.
   assign sum_hi  = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_nxt = {sum_hi, acc_q[N-1:1]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (xfer) state_d = zero_op ? DONE : RUN;
         RUN:  if (cnt_q == CW'(1)) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         p_q      <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            mcand_q  <= mag(x, sgn);
            mplier_q <= mag(y, sgn);
            neg_q    <= sgn && (x[N-1] ^ y[N-1]) && !zero_op;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
            if (zero_op) p_q <= '0;
         end else if (state_q == RUN) begin
            acc_q    <= acc_nxt;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) p_q <= neg_q ? neg2(acc_nxt) : acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_seq_mul_hs.sv
// Directed-vector bench for seq_mul_hs (N=8); honours SEQ_MUL_ZERO_SKIP_EN for the zero-operand latency.
module tb_seq_mul_hs;
   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N-1:0]   x = '0;
   logic [N-1:0]   y = '0;
   logic           sgn = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [2*N-1:0] p;
   logic           busy;

   int n_chk = 0;
   int n_err = 0;

`ifdef SEQ_MUL_ZERO_SKIP_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = N + 1;
`endif

   seq_mul_hs #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
      .p(p), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present operands at a negedge so the transfer happens at the following posedge.
   task automatic xfer_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      x = a; y = b; sgn = s; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Latency counts edges from the transfer until out_valid is first seen high.
   task automatic wait_out(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic s, input logic [2*N-1:0] exp_p, input int exp_lat);
      int lat;
      out_ready = 1'b1;
      xfer_op(a, b, s);
      wait_out(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_p"}, 32'(p), 32'(exp_p));
      @(posedge clk);
      #1;
      check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_p", 32'(p), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel_in_ready", 32'(in_ready), 32'd1);

      run_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, N + 1);
      run_op("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000, N + 1);
      run_op("s_m128_1", 8'h80, 8'h01, 1'b1, 16'hFF80, N + 1);
      run_op("s_7_m3", 8'h07, 8'hFD, 1'b1, 16'hFFEB, N + 1);
      run_op("s_m1_m1", 8'hFF, 8'hFF, 1'b1, 16'h0001, N + 1);
      run_op("s_127_m128", 8'h7F, 8'h80, 1'b1, 16'hC080, N + 1);
      run_op("u_80_80", 8'h80, 8'h80, 1'b0, 16'h4000, N + 1);
      run_op("u_fd_7", 8'hFD, 8'h07, 1'b0, 16'h06EB, N + 1);

      // Backpressure: result must hold while inputs churn and no new transfer is taken.
      out_ready = 1'b0;
      xfer_op(8'd13, 8'd11, 1'b0);
      wait_out(lat);
      check("bp_lat", 32'(lat), 32'(N + 1));
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x = 8'(i * 37 + 1);
         y = 8'(i * 53 + 2);
         @(negedge clk);
         check("bp_p", 32'(p), 32'd143);
         check("bp_vld", 32'(out_valid), 32'd1);
         check("bp_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_done", 32'(out_valid), 32'd0);
      check("bp_p_hold", 32'(p), 32'd143);

      // Abort during the fourth RUN cycle.
      xfer_op(8'd200, 8'd3, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_vld", 32'(out_valid), 32'd0);
      check("abort_p", 32'(p), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("abort_no_vld", 32'(out_valid), 32'd0);
      run_op("after_abort", 8'd2, 8'd3, 1'b0, 16'd6, N + 1);

      run_op("zero_x", 8'd0, 8'h5A, 1'b1, 16'h0000, ZERO_LAT);
      run_op("zero_y_neg", 8'h85, 8'd0, 1'b1, 16'h0000, ZERO_LAT);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
